// File: rtl/w5500_pkg.sv
// Shared encodings for the W5500 task arbiter: phase/channel states,
// o_task_state codes and the W5500 transfer field widths.
package w5500_pkg;

    localparam int CMD_W  = 8;
    localparam int ADDR_W = 16;
    localparam int DAT_W  = 8;

    typedef enum logic [1:0] {
        P_INI = 2'd0,
        P_SNI = 2'd1,
        P_RUN = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_BUSY = 2'd1,
        C_GAP  = 2'd2
    } chan_t;

    localparam logic [3:0] ST_GAP   = 4'd6;
    localparam logic [3:0] ST_ABORT = 4'd7;

    // Phase encoding is chosen so that {phase, busy} directly yields codes 0..5.
    function automatic logic [3:0] task_code(input phase_t ph, input chan_t ch, input logic abort);
        logic [3:0] code;
        if (abort)
            code = ST_ABORT;
        else if (ch == C_GAP)
            code = ST_GAP;
        else
            code = {1'b0, ph, (ch == C_BUSY)};
        return code;
    endfunction

endpackage

// File: rtl/w5500_task_arb_rr_pick.sv
// Rotate-priority picker: returns the first requesting socket at or after rr,
// wrapping modulo NUM_SN (works for non-power-of-two socket counts).
module rr_pick #(
    parameter int NUM_SN = 2,
    parameter int IDX_W  = 1
) (
    input  logic [NUM_SN-1:0] req,
    input  logic [IDX_W-1:0]  rr,
    output logic              vld,
    output logic [IDX_W-1:0]  idx
);

    logic [NUM_SN-1:0][IDX_W-1:0] cand;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SN; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum = {1'b0, rr} + (IDX_W+1)'(gi);
            assign cand[gi] = (sum >= (IDX_W+1)'(NUM_SN)) ? IDX_W'(sum - (IDX_W+1)'(NUM_SN))
                                                          : sum[IDX_W-1:0];
        end
    endgenerate

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        idx = '0;
        for (int i = NUM_SN - 1; i >= 0; i--) begin
            if (req[cand[i]])
                idx = cand[i];
        end
    end

    assign vld = |req;

endmodule

// File: rtl/w5500_task_arb.sv
// Shares one W5500 SPI driver between the chip-init engine and NUM_SN socket engines,
// sequencing init -> socket init -> round-robin run. Optional watchdog: W5500_ARB_WDOG_EN.
module w5500_task_arb
    import w5500_pkg::*;
#(
    parameter int NUM_SN   = 2,
    parameter int LEN_W    = 16,
    parameter int WDOG_CYC = 65535
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ini_vld,
    input  logic [CMD_W-1:0]         ini_cmd,
    input  logic [ADDR_W-1:0]        ini_addr,
    input  logic [DAT_W-1:0]         ini_dat,
    input  logic [LEN_W-1:0]         ini_len,
    input  logic                     ini_end,
    input  logic [NUM_SN-1:0]        sn_vld,
    input  logic [NUM_SN*CMD_W-1:0]  sn_cmd,
    input  logic [NUM_SN*ADDR_W-1:0] sn_addr,
    input  logic [NUM_SN*DAT_W-1:0]  sn_dat,
    input  logic [NUM_SN*LEN_W-1:0]  sn_len,
    input  logic [NUM_SN-1:0]        sn_ini_end,
    input  logic                     wic_end,
    output logic                     o_ini_vld,
    output logic [NUM_SN-1:0]        o_sn_vld,
    output logic                     o_wic_vld,
    output logic [CMD_W-1:0]         o_wic_cmd,
    output logic [ADDR_W-1:0]        o_wic_addr,
    output logic [DAT_W-1:0]         o_wic_dat,
    output logic [LEN_W-1:0]         o_wic_len,
    output logic [NUM_SN:0]          o_grant,
    output logic [NUM_SN:0]          o_done,
    output logic [3:0]               o_task_state,
    output logic                     o_timeout
);

    localparam int IDX_W = (NUM_SN > 1) ? $clog2(NUM_SN) : 1;
    localparam int GNT_W = NUM_SN + 1;

    phase_t             phase_reg, phase_next;
    chan_t              chan_reg, chan_next;
    logic [IDX_W-1:0]   idx_reg, idx_next, rr_reg, rr_next;
    logic [IDX_W-1:0]   pick_idx, sel_idx;
    logic               pick_vld, req_elig, end_pulse, wdog_hit;
    logic               adv_flag_reg, adv_flag_next;
    logic [GNT_W-1:0]   grant_reg, grant_next, done_reg, done_next;
    logic               wic_vld_reg, wic_vld_next, timeout_reg, timeout_next;
    logic               ini_en_reg, ini_en_next;
    logic [NUM_SN-1:0]  sn_en_reg, sn_en_next;
    logic [CMD_W-1:0]   cmd_reg, cmd_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [DAT_W-1:0]   dat_reg, dat_next;
    logic [LEN_W-1:0]   len_reg, len_next;

    rr_pick #(.NUM_SN(NUM_SN), .IDX_W(IDX_W)) u_rr_pick (
        .req (sn_vld),
        .rr  (rr_reg),
        .vld (pick_vld),
        .idx (pick_idx)
    );

`ifdef W5500_ARB_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYC + 1);
    logic [WDOG_W-1:0] wdog_reg;

    // Counts completed busy cycles; holds 0 outside C_BUSY so each grant starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wdog_reg <= '0;
        else if (chan_reg == C_BUSY)
            wdog_reg <= wdog_reg + WDOG_W'(1);
        else
            wdog_reg <= '0;
    end

    assign wdog_hit = (chan_reg == C_BUSY) && (wdog_reg == WDOG_W'(WDOG_CYC - 1));
`else
    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        phase_next    = phase_reg;
        chan_next     = chan_reg;
        idx_next      = idx_reg;
        rr_next       = rr_reg;
        adv_flag_next = adv_flag_reg;
        grant_next    = grant_reg;
        done_next     = '0;
        wic_vld_next  = 1'b0;
        timeout_next  = 1'b0;
        cmd_next      = cmd_reg;
        addr_next     = addr_reg;
        dat_next      = dat_reg;
        len_next      = len_reg;

        end_pulse = ((phase_reg == P_INI) && ini_end) ||
                    ((phase_reg == P_SNI) && sn_ini_end[idx_reg]);
        sel_idx   = (phase_reg == P_RUN) ? pick_idx : idx_reg;
        case (phase_reg)
            P_INI:   req_elig = ini_vld;
            P_SNI:   req_elig = sn_vld[idx_reg];
            default: req_elig = pick_vld;
        endcase

        case (chan_reg)
            C_IDLE: begin
                // A pending phase advance takes the idle cycle; no grant under the old phase.
                if (adv_flag_reg || end_pulse) begin
                    adv_flag_next = 1'b0;
                    if (phase_reg == P_INI) begin
                        phase_next = P_SNI;
                        idx_next   = '0;
                    end else if (phase_reg == P_SNI) begin
                        if (idx_reg == IDX_W'(NUM_SN - 1))
                            phase_next = P_RUN;
                        else
                            idx_next = idx_reg + IDX_W'(1);
                    end
                end else if (req_elig) begin
                    chan_next    = C_BUSY;
                    wic_vld_next = 1'b1;
                    if (phase_reg == P_INI) begin
                        grant_next = GNT_W'(1);
                        cmd_next   = ini_cmd;
                        addr_next  = ini_addr;
                        dat_next   = ini_dat;
                        len_next   = ini_len;
                    end else begin
                        grant_next = GNT_W'(2) << sel_idx;
                        cmd_next   = sn_cmd[sel_idx*CMD_W +: CMD_W];
                        addr_next  = sn_addr[sel_idx*ADDR_W +: ADDR_W];
                        dat_next   = sn_dat[sel_idx*DAT_W +: DAT_W];
                        len_next   = sn_len[sel_idx*LEN_W +: LEN_W];
                        if (phase_reg == P_RUN)
                            rr_next = (sel_idx == IDX_W'(NUM_SN - 1)) ? '0 : sel_idx + IDX_W'(1);
                    end
                end
            end
            C_BUSY: begin
                if (wic_end) begin
                    done_next  = grant_reg;
                    grant_next = '0;
                    chan_next  = C_GAP;
                end else if (wdog_hit) begin
                    timeout_next = 1'b1;
                    grant_next   = '0;
                    chan_next    = C_GAP;
                end
            end
            default: chan_next = C_IDLE;
        endcase

        if ((chan_reg != C_IDLE) && end_pulse)
            adv_flag_next = 1'b1;

        ini_en_next = (phase_next == P_INI);
        sn_en_next  = (phase_next == P_SNI) ? (NUM_SN'(1) << idx_next) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg    <= P_INI;
            chan_reg     <= C_IDLE;
            idx_reg      <= '0;
            rr_reg       <= '0;
            adv_flag_reg <= 1'b0;
            grant_reg    <= '0;
            done_reg     <= '0;
            wic_vld_reg  <= 1'b0;
            timeout_reg  <= 1'b0;
            ini_en_reg   <= 1'b0;
            sn_en_reg    <= '0;
            cmd_reg      <= '0;
            addr_reg     <= '0;
            dat_reg      <= '0;
            len_reg      <= '0;
        end else begin
            phase_reg    <= phase_next;
            chan_reg     <= chan_next;
            idx_reg      <= idx_next;
            rr_reg       <= rr_next;
            adv_flag_reg <= adv_flag_next;
            grant_reg    <= grant_next;
            done_reg     <= done_next;
            wic_vld_reg  <= wic_vld_next;
            timeout_reg  <= timeout_next;
            ini_en_reg   <= ini_en_next;
            sn_en_reg    <= sn_en_next;
            cmd_reg      <= cmd_next;
            addr_reg     <= addr_next;
            dat_reg      <= dat_next;
            len_reg      <= len_next;
        end
    end

    assign o_ini_vld    = ini_en_reg;
    assign o_sn_vld     = sn_en_reg;
    assign o_wic_vld    = wic_vld_reg;
    assign o_wic_cmd    = cmd_reg;
    assign o_wic_addr   = addr_reg;
    assign o_wic_dat    = dat_reg;
    assign o_wic_len    = len_reg;
    assign o_grant      = grant_reg;
    assign o_done       = done_reg;
    assign o_timeout    = timeout_reg;
    assign o_task_state = task_code(phase_reg, chan_reg, timeout_reg);

endmodule

// File: tb/tb_w5500_task_arb.sv
// Self-checking bench for w5500_task_arb with NUM_SN=3: directed phase sequencing,
// a socket-init table, and randomized round-robin traffic against a reference model.
module tb_w5500_task_arb;

    localparam int N  = 3;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ini_vld, ini_end, wic_end;
    logic [7:0]      ini_cmd, ini_dat;
    logic [15:0]     ini_addr;
    logic [LW-1:0]   ini_len;
    logic [N-1:0]    sn_vld, sn_ini_end;
    logic [N*8-1:0]  sn_cmd, sn_dat;
    logic [N*16-1:0] sn_addr;
    logic [N*LW-1:0] sn_len;
    logic            o_ini_vld, o_wic_vld, o_timeout;
    logic [N-1:0]    o_sn_vld;
    logic [7:0]      o_wic_cmd, o_wic_dat;
    logic [15:0]     o_wic_addr;
    logic [LW-1:0]   o_wic_len;
    logic [N:0]      o_grant, o_done;
    logic [3:0]      o_task_state;

    w5500_task_arb #(.NUM_SN(N), .LEN_W(LW), .WDOG_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ini_vld(ini_vld), .ini_cmd(ini_cmd), .ini_addr(ini_addr), .ini_dat(ini_dat),
        .ini_len(ini_len), .ini_end(ini_end),
        .sn_vld(sn_vld), .sn_cmd(sn_cmd), .sn_addr(sn_addr), .sn_dat(sn_dat),
        .sn_len(sn_len), .sn_ini_end(sn_ini_end), .wic_end(wic_end),
        .o_ini_vld(o_ini_vld), .o_sn_vld(o_sn_vld), .o_wic_vld(o_wic_vld),
        .o_wic_cmd(o_wic_cmd), .o_wic_addr(o_wic_addr), .o_wic_dat(o_wic_dat),
        .o_wic_len(o_wic_len), .o_grant(o_grant), .o_done(o_done),
        .o_task_state(o_task_state), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rr_m   = 0;   // model's round-robin start position

    typedef struct {
        logic [N-1:0] pulse;
        logic [N-1:0] exp_sn;
        logic [3:0]   exp_state;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        for (int k = 0; k < N; k++) begin
            sn_cmd[k*8 +: 8]    = 8'($urandom);
            sn_dat[k*8 +: 8]    = 8'($urandom);
            sn_addr[k*16 +: 16] = 16'($urandom);
            sn_len[k*LW +: LW]  = LW'($urandom);
        end
    endtask

    // One P_RUN transaction: request, grant, random busy length, done, gap.
    task automatic run_txn(input logic [N-1:0] req, output logic [N:0] gnt_seen);
        int w;
        int nw;
        logic [7:0]    ec, ed;
        logic [15:0]   ea;
        logic [LW-1:0] el;
        logic [N:0]    eg;
        w = -1;
        for (int o = 0; o < N; o++)
            if (w < 0 && req[(rr_m + o) % N]) w = (rr_m + o) % N;
        scramble();
        sn_vld = req;
        tick();
        gnt_seen = o_grant;
        if (w < 0) begin
            chk("noreq_wic_vld", o_wic_vld, 0);
            chk("noreq_grant", o_grant, 0);
            chk("noreq_state", o_task_state, 4);
            $display("txn req=%b no grant", req);
        end else begin
            ec = sn_cmd[w*8 +: 8];
            ed = sn_dat[w*8 +: 8];
            ea = sn_addr[w*16 +: 16];
            el = sn_len[w*LW +: LW];
            eg = '0;
            eg[w+1] = 1'b1;
            chk("run_wic_vld", o_wic_vld, 1);
            chk("run_grant", o_grant, eg);
            chk("run_cmd", o_wic_cmd, ec);
            chk("run_addr", o_wic_addr, ea);
            chk("run_dat", o_wic_dat, ed);
            chk("run_len", o_wic_len, el);
            chk("run_state", o_task_state, 5);
            rr_m = (w + 1) % N;
            scramble();
            nw = $urandom_range(0, 3);
            for (int c = 0; c < nw; c++) begin
                tick();
                chk("busy_wic_vld", o_wic_vld, 0);
                chk("busy_cmd_stable", o_wic_cmd, ec);
                chk("busy_len_stable", o_wic_len, el);
            end
            wic_end = 1'b1;
            tick();
            wic_end = 1'b0;
            sn_vld  = '0;
            chk("run_done", o_done, eg);
            chk("run_grant_clr", o_grant, 0);
            chk("run_gap_state", o_task_state, 6);
            tick();
            chk("run_done_clr", o_done, 0);
            chk("run_idle_state", o_task_state, 4);
            $display("txn req=%b socket=%0d grant=%b", req, w, o_grant);
        end
    endtask

    logic [N:0] g;
    logic [N:0] rr_exp[4];

    initial begin
        tbl[0] = '{pulse: 3'b100, exp_sn: 3'b001, exp_state: 4'd2};
        tbl[1] = '{pulse: 3'b001, exp_sn: 3'b010, exp_state: 4'd2};
        tbl[2] = '{pulse: 3'b001, exp_sn: 3'b010, exp_state: 4'd2};
        tbl[3] = '{pulse: 3'b010, exp_sn: 3'b100, exp_state: 4'd2};
        tbl[4] = '{pulse: 3'b100, exp_sn: 3'b000, exp_state: 4'd4};
        rr_exp[0] = 4'b0010;
        rr_exp[1] = 4'b0100;
        rr_exp[2] = 4'b1000;
        rr_exp[3] = 4'b0010;

        ini_vld = 0; ini_end = 0; wic_end = 0;
        ini_cmd = 0; ini_dat = 0; ini_addr = 0; ini_len = 0;
        sn_vld = 0; sn_ini_end = 0; sn_cmd = 0; sn_dat = 0; sn_addr = 0; sn_len = 0;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_grant", o_grant, 0);
        chk("rst_done", o_done, 0);
        chk("rst_wic_vld", o_wic_vld, 0);
        chk("rst_ini_vld", o_ini_vld, 0);
        chk("rst_sn_vld", o_sn_vld, 0);
        chk("rst_state", o_task_state, 0);
        chk("rst_timeout", o_timeout, 0);
        chk("rst_cmd", o_wic_cmd, 0);
        rst_n = 1'b1;
        tick();
        chk("ini_en", o_ini_vld, 1);
        chk("ini_idle_state", o_task_state, 0);

        // Init-engine transfer
        ini_vld = 1; ini_cmd = 8'h04; ini_addr = 16'h0001; ini_dat = 8'hA5; ini_len = 1;
        tick();
        chk("ini_wic_vld", o_wic_vld, 1);
        chk("ini_grant", o_grant, 1);
        chk("ini_cmd", o_wic_cmd, 8'h04);
        chk("ini_addr", o_wic_addr, 16'h0001);
        chk("ini_dat", o_wic_dat, 8'hA5);
        chk("ini_len", o_wic_len, 1);
        chk("ini_busy_state", o_task_state, 1);
        ini_cmd = 8'h55; ini_addr = 16'hBEEF;
        tick();
        chk("ini_wic_pulse", o_wic_vld, 0);
        chk("ini_cmd_hold", o_wic_cmd, 8'h04);
        chk("ini_addr_hold", o_wic_addr, 16'h0001);
        wic_end = 1;
        tick();
        wic_end = 0; ini_vld = 0;
        chk("ini_done", o_done, 1);
        chk("ini_grant_clr", o_grant, 0);
        chk("ini_gap_state", o_task_state, 6);
        tick();
        chk("ini_done_clr", o_done, 0);
        chk("ini_back_idle", o_task_state, 0);

        // ini_end during C_BUSY is deferred until the channel is idle again
        ini_vld = 1;
        tick();
        chk("defer_busy", o_task_state, 1);
        ini_end = 1;
        tick();
        ini_end = 0;
        chk("defer_ini_en", o_ini_vld, 1);
        chk("defer_still_ini", o_task_state, 1);
        wic_end = 1; ini_vld = 0;
        tick();
        wic_end = 0;
        chk("defer_gap", o_task_state, 6);
        chk("defer_done", o_done, 1);
        tick();
        chk("defer_idle", o_task_state, 0);
        chk("defer_idle_ini_en", o_ini_vld, 1);
        tick();
        chk("sni_state", o_task_state, 2);
        chk("sni_ini_off", o_ini_vld, 0);
        chk("sni_sn0", o_sn_vld, 3'b001);

        // In P_SNI only socket idx is eligible
        sn_vld = 3'b010;
        tick();
        chk("sni_other_ignored", o_wic_vld, 0);
        chk("sni_other_nogrant", o_grant, 0);
        scramble();
        sn_vld = 3'b011;
        tick();
        chk("sni_grant", o_grant, 4'b0010);
        chk("sni_cmd", o_wic_cmd, sn_cmd[7:0]);
        chk("sni_addr", o_wic_addr, sn_addr[15:0]);
        wic_end = 1; sn_vld = 0;
        tick();
        wic_end = 0;
        chk("sni_done", o_done, 4'b0010);
        tick();
        chk("sni_idle", o_task_state, 2);

        // Socket-init walk with stray pulses on non-current sockets
        for (int i = 0; i < 5; i++) begin
            sn_ini_end = tbl[i].pulse;
            tick();
            sn_ini_end = '0;
            chk($sformatf("walk%0d_sn_vld", i), o_sn_vld, tbl[i].exp_sn);
            chk($sformatf("walk%0d_state", i), o_task_state, tbl[i].exp_state);
        end

        // Round robin with all sockets requesting
        for (int i = 0; i < 4; i++) begin
            run_txn(3'b111, g);
            chk($sformatf("rr_order%0d", i), g, rr_exp[i]);
        end

        // Random request patterns against the model
        for (int i = 0; i < 40; i++)
            run_txn(N'($urandom_range(0, 7)), g);

        // ini_vld and wic_end while idle in P_RUN have no effect
        ini_vld = 1; wic_end = 1;
        tick();
        wic_end = 0; ini_vld = 0;
        chk("idle_wic_end_done", o_done, 0);
        chk("idle_ini_ignored", o_wic_vld, 0);
        chk("idle_wic_end_state", o_task_state, 4);

        // Reset asserted mid-transfer
        sn_vld = 3'b100;
        tick();
        chk("mid_busy", o_task_state, 5);
        rst_n = 0;
        #1;
        chk("arst_grant", o_grant, 0);
        chk("arst_state", o_task_state, 0);
        chk("arst_sn_vld", o_sn_vld, 0);
        wic_end = 1;
        tick();
        wic_end = 0; sn_vld = 0;
        chk("arst_no_done", o_done, 0);
        chk("arst_wic_vld", o_wic_vld, 0);
        rst_n = 1;
        tick();
        chk("arst_restart_ini", o_ini_vld, 1);
        chk("arst_restart_state", o_task_state, 0);
        chk("arst_restart_done", o_done, 0);

`ifdef W5500_ARB_WDOG_EN
        ini_vld = 1;
        tick();
        chk("wdog_grant", o_grant, 1);
        for (int c = 2; c <= 16; c++) begin
            tick();
            chk("wdog_quiet", o_timeout, 0);
        end
        tick();
        ini_vld = 0;
        chk("wdog_timeout", o_timeout, 1);
        chk("wdog_state7", o_task_state, 7);
        chk("wdog_no_done", o_done, 0);
        chk("wdog_grant_clr", o_grant, 0);
        tick();
        chk("wdog_pulse_end", o_timeout, 0);
        chk("wdog_idle", o_task_state, 0);
        ini_vld = 1;
        tick();
        chk("wdog_regrant", o_grant, 1);
        chk("wdog_regrant_vld", o_wic_vld, 1);
`else
        ini_vld = 1;
        repeat (20) tick();
        chk("nowdog_timeout", o_timeout, 0);
        chk("nowdog_still_busy", o_task_state, 1);
        chk("nowdog_grant", o_grant, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/w5500_task_arb.md
Name: w5500_task_arb

Overview:
Parametrised successor to the fixed two-client scheduler. Arbitrates one W5500 SPI driver between the chip-init engine and NUM_SN socket engines. Sequences the power-up phases: chip init, then per-socket init in index order, then round-robin run. Sits between ini_w5500 / socket instances and spi_drv inside the W5500 top.

Parameters:
NUM_SN, 2, number of socket engines (1..8)
LEN_W, 16, width of the transfer-length fields
WDOG_CYC, 65535, watchdog limit in clk cycles (used only with W5500_ARB_WDOG_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ini_vld  in  1  init engine request (level, held until its done pulse)
ini_cmd/ini_addr/ini_dat  in  8/16/8  init transfer fields
ini_len  in  LEN_W  init transfer length
ini_end  in  1  chip init complete (pulse)
sn_vld  in  NUM_SN  per-socket request (level, held until done)
sn_cmd/sn_dat  in  NUM_SN*8  packed socket fields; socket k at [8k+7:8k]
sn_addr  in  NUM_SN*16  packed socket addresses
sn_len  in  NUM_SN*LEN_W  packed socket lengths
sn_ini_end  in  NUM_SN  socket k init complete (pulse)
wic_end  in  1  spi_drv transfer finished (opr_end)
o_ini_vld  out  1  init engine enable
o_sn_vld  out  NUM_SN  one-hot socket-init enable
o_wic_vld  out  1  spi_drv start, 1-cycle pulse
o_wic_cmd/o_wic_addr/o_wic_dat/o_wic_len  out  8/16/8/LEN_W  latched transfer fields
o_grant  out  NUM_SN+1  one-hot current owner; bit 0 = init, bit k+1 = socket k
o_done  out  NUM_SN+1  completion pulse to owner, same bit map
o_task_state  out  4  phase/channel state code
o_timeout  out  1  watchdog abort pulse (0 when feature absent)

Behaviour:
- Reset: all outputs 0; phase = P_INI; chan = C_IDLE; rr pointer = 0; socket-init index = 0.
- Phase FSM: P_INI (o_ini_vld=1; init is the only eligible requester) -> ini_end -> P_SNI. P_SNI: o_sn_vld[idx]=1; only socket idx eligible; sn_ini_end[idx] -> idx+1; after the last socket -> P_RUN. P_RUN: all sn_vld eligible; ini_vld ignored. P_RUN is terminal until reset.
- sn_ini_end on a bit other than idx is ignored. ini_end outside P_INI is ignored.
- Phase advance is deferred while chan != C_IDLE; the end pulse is captured in a sticky flag.
- Channel FSM:
  - C_IDLE: on an eligible request at cycle t, latch owner and fields; o_grant set at t+1; o_wic_vld=1 at t+1 only. -> C_BUSY.
  - C_BUSY: wait for wic_end. On wic_end, o_done[owner]=1 for 1 cycle, o_grant cleared. -> C_GAP.
  - C_GAP: one dead cycle so the requester can drop vld. -> C_IDLE.
- Round-robin in P_RUN: search starts at rr; winner w; rr <- (w+1) mod NUM_SN at grant. Modulo wrap handles NUM_SN not a power of two.
- Fields stay stable on o_wic_* from grant until the next grant. Request fields changing during C_BUSY have no effect.
- wic_end in C_IDLE/C_GAP is ignored.
- o_task_state: 0 P_INI idle, 1 P_INI busy, 2 P_SNI idle, 3 P_SNI busy, 4 P_RUN idle, 5 P_RUN busy, 6 any C_GAP, 7 watchdog abort cycle.
- Reset asserted mid-transfer: immediate return to reset values; no done pulse.

Optional Feature:
W5500_ARB_WDOG_EN
- Defined: a counter runs in C_BUSY. On reaching WDOG_CYC without wic_end, o_timeout pulses (1 cycle), o_done[owner] does not pulse, grant is released and chan -> C_GAP; state code 7 is shown in that cycle.
- Undefined: no counter; o_timeout tied 0; C_BUSY waits indefinitely.

Decomposition:
- Package w5500_pkg: phase/channel state encodings, o_task_state codes, W5500 field widths (CMD_W=8, ADDR_W=16, DAT_W=8).
- Sub-module rr_pick (NUM_SN): combinational rotate-priority picker; inputs req vector and rr, outputs valid + index.
- FSMs and field latches stay in the top.

Test Plan:
- Reset, ini_vld=1 cmd=0x04 addr=0x0001 len=1 -> o_wic_vld pulse 1 cycle later with those fields; wic_end -> o_done[0] pulse, then state 6 then 0.
- NUM_SN=3: ini_end, then sn_ini_end to 0,1,2 in order -> o_sn_vld walks 001, 010, 100 then 000, state 4; a stray sn_ini_end[2] while idx=0 -> no advance.
- P_RUN with sn_vld=111 held, each done followed by a drop-and-reassert -> grants in order socket0, 1, 2, 0.
- ini_end arrives during C_BUSY -> phase stays P_INI until C_GAP->C_IDLE, then P_SNI.
- Reset pulsed mid C_BUSY -> all outputs 0 next edge; no o_done.
- W5500_ARB_WDOG_EN defined, WDOG_CYC=16, wic_end withheld -> o_timeout at busy cycle 16, no o_done, next requester is granted.
